// File: rtl/bounce_gen_pkg.sv
// Shared types and constants for the contact-bounce generator.
// The LFSR step helper is only used when BOUNCE_GEN_RANDOM_EN is defined.
package bounce_gen_pkg;

  typedef enum logic [2:0] {
    IDLE,
    PRESS_B,
    HOLD,
    REL_B,
    FIN
  } bg_state_t;

  localparam logic [15:0] LFSR_TAPS = 16'hB400;

  // Galois form: shift right, fold the taps back in when a one falls out.
  function automatic logic [15:0] lfsr_step(input logic [15:0] q);
    return q[0] ? ((q >> 1) ^ LFSR_TAPS) : (q >> 1);
  endfunction

endpackage

// File: rtl/lfsr16.sv
// 16-bit Galois LFSR that advances one step per adv_i pulse.
// Only elaborated when BOUNCE_GEN_RANDOM_EN is defined; the fixed-width build has no LFSR.
`ifdef BOUNCE_GEN_RANDOM_EN
module lfsr16
  import bounce_gen_pkg::*;
#(
  parameter logic [15:0] SEED = 16'hACE1
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        adv_i,
  output logic [15:0] q_o
);

  logic [15:0] q_q;
  logic [15:0] q_d;

  always_comb begin
    q_d = q_q;
    if (adv_i) begin
      q_d = lfsr_step(q_q);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      q_q <= SEED;
    end else begin
      q_q <= q_d;
    end
  end

  assign q_o = q_q;

endmodule
`endif

// File: rtl/button_bounce_gen.sv
// Pushbutton emulator: bouncy press, stable hold, bouncy release per start request.
// Define BOUNCE_GEN_RANDOM_EN for LFSR-driven segment widths; otherwise every segment is BOUNCE_W.
module button_bounce_gen
  import bounce_gen_pkg::*;
#(
  parameter int unsigned NUM_BOUNCES = 2,
  parameter int unsigned BOUNCE_W    = 3,
  parameter int unsigned WIDTH_BITS  = 4,
  parameter int unsigned HOLD_CYCLES = 20,
  parameter logic [15:0] SEED        = 16'hACE1
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic start_i,
  input  logic abort_i,
  output logic bot_o,
  output logic busy_o,
  output logic done_o
);

  localparam int unsigned NumSegs = 2 * NUM_BOUNCES;
  localparam int unsigned SegW    = WIDTH_BITS + 1;
  localparam int unsigned HoldW   = $clog2(HOLD_CYCLES + 1);
  localparam int unsigned IdxW    = $clog2(NumSegs + 1);

  localparam logic [IdxW-1:0]  LastIdx  = IdxW'(NumSegs - 1);
  localparam logic [HoldW-1:0] HoldLoad = HoldW'(HOLD_CYCLES - 1);

  if (NUM_BOUNCES < 1 || BOUNCE_W < 1 || HOLD_CYCLES < 1 || WIDTH_BITS < 1 ||
      WIDTH_BITS > 15 || BOUNCE_W > (1 << SegW) || SEED == 16'h0) begin : g_param_check
    $error("button_bounce_gen: illegal parameter combination");
  end

  bg_state_t        state_q, state_d;
  logic [IdxW-1:0]  idx_q, idx_d;
  logic [HoldW-1:0] hold_cnt_q, hold_cnt_d;
  logic [SegW-1:0]  seg_cnt_q, seg_cnt_d;
  logic [SegW-1:0]  seg_load;
  logic             seg_start;
  logic             seg_dec;
  logic             bot_q, bot_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

`ifdef BOUNCE_GEN_RANDOM_EN
  logic [15:0] lfsr_q;

  // Width is taken from the value present at load; the LFSR steps in the same cycle.
  lfsr16 #(
    .SEED(SEED)
  ) u_lfsr (
    .clk_i (clk_i),
    .rst_ni(rst_ni),
    .adv_i (seg_start),
    .q_o   (lfsr_q)
  );

  assign seg_load = {1'b0, lfsr_q[WIDTH_BITS-1:0]};
`else
  assign seg_load = SegW'(BOUNCE_W - 1);
`endif

  // State register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state and counter control.
  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    hold_cnt_d = hold_cnt_q;
    seg_start  = 1'b0;
    seg_dec    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start_i) begin
          state_d   = PRESS_B;
          idx_d     = '0;
          seg_start = 1'b1;
        end
      end
      PRESS_B, REL_B: begin
        if (seg_cnt_q == '0) begin
          if (idx_q == LastIdx) begin
            state_d    = (state_q == PRESS_B) ? HOLD : FIN;
            hold_cnt_d = (state_q == PRESS_B) ? HoldLoad : '0;
            idx_d      = '0;
          end else begin
            idx_d     = idx_q + 1'b1;
            seg_start = 1'b1;
          end
        end else begin
          seg_dec = 1'b1;
        end
      end
      HOLD: begin
        if (hold_cnt_q == '0) begin
          state_d   = REL_B;
          idx_d     = '0;
          seg_start = 1'b1;
        end else begin
          hold_cnt_d = hold_cnt_q - 1'b1;
        end
      end
      FIN: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // Abort beats everything, including a start seen in the same IDLE cycle.
    if (abort_i) begin
      state_d    = IDLE;
      idx_d      = '0;
      hold_cnt_d = '0;
      seg_start  = 1'b0;
      seg_dec    = 1'b0;
    end
  end

  always_comb begin
    seg_cnt_d = seg_cnt_q;
    if (seg_start) begin
      seg_cnt_d = seg_load;
    end else if (seg_dec) begin
      seg_cnt_d = seg_cnt_q - 1'b1;
    end
    if (abort_i) begin
      seg_cnt_d = '0;
    end
  end

  // Outputs follow the current state one cycle later, except abort clears them at once.
  always_comb begin
    bot_d  = 1'b0;
    busy_d = 1'b0;
    done_d = 1'b0;
    unique case (state_q)
      PRESS_B: begin
        bot_d  = ~idx_q[0];
        busy_d = 1'b1;
      end
      HOLD: begin
        bot_d  = 1'b1;
        busy_d = 1'b1;
      end
      REL_B: begin
        bot_d  = idx_q[0];
        busy_d = 1'b1;
      end
      FIN: begin
        done_d = 1'b1;
      end
      default: begin
        bot_d = 1'b0;
      end
    endcase
    if (abort_i) begin
      bot_d  = 1'b0;
      busy_d = 1'b0;
      done_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      idx_q      <= '0;
      hold_cnt_q <= '0;
      seg_cnt_q  <= '0;
      bot_q      <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      idx_q      <= idx_d;
      hold_cnt_q <= hold_cnt_d;
      seg_cnt_q  <= seg_cnt_d;
      bot_q      <= bot_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  assign bot_o  = bot_q;
  assign busy_o = busy_q;
  assign done_o = done_q;

endmodule
